dmem_port_ctrl: RTL and testbench

Data-side responder for the core's load/store port: accepts the memory-stage operation (lsu op, address, store data, atomic qualifiers), drives a single-port backing data memory through a req/ack handshake, and returns load data, AMO old values and SC status. While an access is outstanding it holds `freeze` high to stall the pipeline. It also owns the LR/SC reservation and the misaligned-access exception.

---
 rtl/dmem_port_ctrl.sv | 144 ++++++++++++++
 tb/tb_dmem_port_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dmem_port_ctrl.sv
// dmem_port_ctrl: load/store/AMO responder to a req/ack data memory, with LR/SC reservation and misalign trap
module dmem_port_ctrl #(
  parameter bit RESV_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  lsu_op,
  input  logic [3:0]  amo_op,
  input  logic        lr,
  input  logic        sc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] amo_load_val,
  output logic        freeze,
  output logic        addr_exception,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  typedef enum logic [2:0] {IDLE, RD, WR, AMO_RD, AMO_WR, DONE} state_t;
  state_t state, state_nx;
  logic [2:0]  sz_q;
  logic [1:0]  lo_q;
  logic        lr_q, sc_q;
  logic [3:0]  amo_q;
  logic [31:0] wdata_q;
  logic        resv_v;
  logic [29:0] resv_a;
  logic        mis, acc, word_match, sc_pass, ack;
  logic [3:0]  st_be;
  logic [31:0] st_data, sh, ld, amo_res;
  assign mis = (lsu_op[3:2] == 2'b01 & addr[0]) | (lsu_op[3:2] == 2'b10 & |addr[1:0]);
  assign acc = lsu_op[0] & ~mis;
  assign word_match = resv_v & (resv_a == addr[31:2]);
  assign sc_pass = RESV_EN & word_match;
  assign ack = mem_ack & mem_req;
  assign st_be = lsu_op[3:2] == 2'b00 ? 4'b0001 << addr[1:0] :
                 lsu_op[3:2] == 2'b01 ? 4'b0011 << {addr[1], 1'b0} : 4'hF;
  assign st_data = lsu_op[3:2] == 2'b00 ? {4{wdata[7:0]}} :
                   lsu_op[3:2] == 2'b01 ? {2{wdata[15:0]}} : wdata;
  assign sh = mem_rdata >> {lo_q, 3'b000};
  assign ld = sz_q == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
              sz_q == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
              sz_q == 3'b100 ? {24'b0, sh[7:0]} :
              sz_q == 3'b101 ? {16'b0, sh[15:0]} : sh;
  always_comb begin
    amo_res = wdata_q;
    case (amo_q)
      4'd2: amo_res = mem_rdata + wdata_q;
      4'd3: amo_res = mem_rdata & wdata_q;
      4'd4: amo_res = mem_rdata | wdata_q;
      4'd5: amo_res = mem_rdata ^ wdata_q;
      4'd6: amo_res = $signed(mem_rdata) > $signed(wdata_q) ? mem_rdata : wdata_q;
      4'd7: amo_res = $signed(mem_rdata) < $signed(wdata_q) ? mem_rdata : wdata_q;
      4'd8: amo_res = mem_rdata > wdata_q ? mem_rdata : wdata_q;
      4'd9: amo_res = mem_rdata < wdata_q ? mem_rdata : wdata_q;
      default: amo_res = wdata_q;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !acc ? IDLE : |amo_op ? AMO_RD : sc ? (sc_pass ? WR : DONE) : lsu_op[1] ? WR : RD;
      RD, WR:  state_nx = ack ? DONE : state;
      AMO_RD:  state_nx = ack ? AMO_WR : AMO_RD;
      AMO_WR:  state_nx = ack ? DONE : AMO_WR;
      default: state_nx = IDLE;
    endcase
  end
  // rst gating keeps the stall and trap low while reset is held, whatever the inputs show
  always_comb begin
    freeze = ~rst & (state == IDLE ? acc : state != DONE);
    addr_exception = ~rst & (state == IDLE) & lsu_op[0] & mis;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sz_q <= '0;
      lo_q <= '0;
      lr_q <= 1'b0;
      sc_q <= 1'b0;
      amo_q <= '0;
      wdata_q <= '0;
      resv_v <= 1'b0;
      resv_a <= '0;
      rdata <= '0;
      amo_load_val <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_be <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          sz_q <= lsu_op[4:2];
          lo_q <= addr[1:0];
          lr_q <= lr;
          sc_q <= sc;
          amo_q <= amo_op;
          wdata_q <= wdata;
          mem_addr <= addr[31:2];
          mem_be <= lsu_op[1] ? st_be : 4'hF;
          mem_wdata <= st_data;
          mem_we <= state_nx == WR;
          mem_req <= state_nx != DONE;
          if (state_nx == DONE) rdata <= 32'd1;
          if (sc | ((lsu_op[1] | |amo_op) & word_match)) resv_v <= 1'b0;
        end
        RD: if (ack) begin
          rdata <= ld;
          mem_req <= 1'b0;
          if (lr_q) begin
            resv_v <= 1'b1;
            resv_a <= mem_addr;
          end
        end
        WR: if (ack) begin
          mem_req <= 1'b0;
          mem_we <= 1'b0;
          if (sc_q) rdata <= 32'd0;
        end
        AMO_RD: if (ack) begin
          amo_load_val <= mem_rdata;
          mem_we <= 1'b1;
          mem_wdata <= amo_res;
        end
        AMO_WR: if (ack) begin
          mem_req <= 1'b0;
          mem_we <= 1'b0;
          rdata <= amo_load_val;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_port_ctrl.sv
// tb_dmem_port_ctrl: directed bench with a byte-enabled memory model and programmable ack delay
module tb_dmem_port_ctrl;
  localparam logic [4:0] LB = 5'b00001, LH = 5'b00101, LW = 5'b01001, LBU = 5'b10001, LHU = 5'b10101;
  localparam logic [4:0] SB = 5'b00011, SH = 5'b00111, SW = 5'b01011;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] lsu_op = '0;
  logic [3:0] amo_op = '0;
  logic lr = 1'b0, sc = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata, amo_load_val, mem_wdata, mem_rdata;
  logic freeze, addr_exception, mem_req, mem_we, mem_ack;
  logic [29:0] mem_addr;
  logic [3:0] mem_be;
  logic [31:0] mem [0:255];
  int wait_n = 0, wcnt;
  int checks = 0, errors = 0;
  int fcnt, reqs;
  logic [3:0] wr_be;
  logic [31:0] wr_data;
  logic [29:0] wr_addr;
  always #5 clk = ~clk;
  dmem_port_ctrl #(.RESV_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .lsu_op(lsu_op), .amo_op(amo_op), .lr(lr), .sc(sc),
    .addr(addr), .wdata(wdata), .rdata(rdata), .amo_load_val(amo_load_val),
    .freeze(freeze), .addr_exception(addr_exception), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );
  assign mem_rdata = mem[mem_addr[7:0]];
  assign mem_ack = mem_req && (wcnt >= wait_n);
  always @(posedge clk or posedge rst)
    if (rst) wcnt <= 0;
    else wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
  always @(posedge clk)
    if (!rst && mem_req && mem_ack && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
  // Presents one op, counts freeze/req cycles until DONE (freeze low), then withdraws it after the DONE edge.
  task automatic run_op(input logic [4:0] op, input logic [3:0] amo, input logic l, input logic s,
                        input logic [31:0] a, input logic [31:0] wd);
    lsu_op = op; amo_op = amo; lr = l; sc = s; addr = a; wdata = wd;
    fcnt = 0; reqs = 0; wr_be = 'x; wr_data = 'x; wr_addr = 'x;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!freeze) break;
      fcnt++;
      if (mem_req) reqs++;
      if (mem_req && mem_we && mem_ack) begin wr_be = mem_be; wr_data = mem_wdata; wr_addr = mem_addr; end
    end
    @(posedge clk); #1;
    lsu_op = '0; amo_op = '0; lr = 1'b0; sc = 1'b0;
  endtask
  task automatic test_reset;
    #2;
    checks++; if ({rdata, amo_load_val, mem_wdata, mem_addr, mem_be, mem_we, mem_req, freeze, addr_exception} !== '0) begin errors++; $display("FAIL reset_outputs got rdata=%h mem_req=%b freeze=%b, all zero required", rdata, mem_req, freeze); end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if ({mem_req, freeze, addr_exception} !== 3'b000) begin errors++; $display("FAIL idle_after_reset got %b exp 000", {mem_req, freeze, addr_exception}); end
  endtask
  task automatic test_load_store;
    run_op(SW, 4'd0, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF);
    checks++; if (fcnt !== 2) begin errors++; $display("FAIL sw_freeze got %0d exp 2", fcnt); end
    checks++; if (wr_be !== 4'hF) begin errors++; $display("FAIL sw_be got %b exp 1111", wr_be); end
    checks++; if (mem[8'h40] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem got %h exp deadbeef", mem[8'h40]); end
    run_op(LB, 4'd0, 1'b0, 1'b0, 32'h103, 32'h0);
    checks++; if (rdata !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb_rdata got %h exp ffffffde", rdata); end
    checks++; if (fcnt !== 2) begin errors++; $display("FAIL lb_freeze got %0d exp 2", fcnt); end
    run_op(LHU, 4'd0, 1'b0, 1'b0, 32'h102, 32'h0);
    checks++; if (rdata !== 32'h0000DEAD) begin errors++; $display("FAIL lhu_rdata got %h exp 0000dead", rdata); end
    checks++; if (fcnt !== 2) begin errors++; $display("FAIL lhu_freeze got %0d exp 2", fcnt); end
    run_op(LH, 4'd0, 1'b0, 1'b0, 32'h100, 32'h0);
    checks++; if (rdata !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh_rdata got %h exp ffffbeef", rdata); end
    run_op(LBU, 4'd0, 1'b0, 1'b0, 32'h101, 32'h0);
    checks++; if (rdata !== 32'h000000BE) begin errors++; $display("FAIL lbu_rdata got %h exp 000000be", rdata); end
    run_op(LW, 4'd0, 1'b0, 1'b0, 32'h100, 32'h0);
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h exp deadbeef", rdata); end
  endtask
  task automatic test_store_lanes;
    run_op(SB, 4'd0, 1'b0, 1'b0, 32'h201, 32'h1234565A);
    checks++; if (wr_be !== 4'b0010) begin errors++; $display("FAIL sb_be got %b exp 0010", wr_be); end
    checks++; if (wr_data !== 32'h5A5A5A5A) begin errors++; $display("FAIL sb_wdata got %h exp 5a5a5a5a", wr_data); end
    checks++; if (wr_addr !== 30'h80) begin errors++; $display("FAIL sb_addr got %h exp 80", wr_addr); end
    run_op(SH, 4'd0, 1'b0, 1'b0, 32'h202, 32'hABCD1234);
    checks++; if (wr_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b exp 1100", wr_be); end
    checks++; if (wr_data !== 32'h12341234) begin errors++; $display("FAIL sh_wdata got %h exp 12341234", wr_data); end
    run_op(LB, 4'd0, 1'b0, 1'b0, 32'h201, 32'h0);
    checks++; if (rdata !== 32'h0000005A) begin errors++; $display("FAIL sb_readback got %h exp 0000005a", rdata); end
  endtask
  task automatic test_amo;
    run_op(SW, 4'd0, 1'b0, 1'b0, 32'h40, 32'hFFFFFFF0);
    run_op(LW, 4'd2, 1'b0, 1'b0, 32'h40, 32'h20);
    checks++; if (amo_load_val !== 32'hFFFFFFF0) begin errors++; $display("FAIL amoadd_old got %h exp fffffff0", amo_load_val); end
    checks++; if (rdata !== 32'hFFFFFFF0) begin errors++; $display("FAIL amoadd_rdata got %h exp fffffff0", rdata); end
    checks++; if (mem[8'h10] !== 32'h10) begin errors++; $display("FAIL amoadd_mem got %h exp 00000010", mem[8'h10]); end
    checks++; if (fcnt !== 3 || reqs !== 2) begin errors++; $display("FAIL amo_latency got freeze=%0d req=%0d exp 3/2", fcnt, reqs); end
    run_op(LW, 4'd6, 1'b0, 1'b0, 32'h40, 32'hFFFFFFFF);
    checks++; if (mem[8'h10] !== 32'h10) begin errors++; $display("FAIL amomax_mem got %h exp 00000010", mem[8'h10]); end
    run_op(LW, 4'd8, 1'b0, 1'b0, 32'h40, 32'hFFFFFFFF);
    checks++; if (mem[8'h10] !== 32'hFFFFFFFF || rdata !== 32'h10) begin errors++; $display("FAIL amomaxu got mem=%h rdata=%h exp ffffffff/00000010", mem[8'h10], rdata); end
    run_op(LW, 4'd5, 1'b0, 1'b0, 32'h40, 32'h0F0F0F0F);
    checks++; if (mem[8'h10] !== 32'hF0F0F0F0) begin errors++; $display("FAIL amoxor_mem got %h exp f0f0f0f0", mem[8'h10]); end
    run_op(LW, 4'd7, 1'b0, 1'b0, 32'h40, 32'h1);
    checks++; if (mem[8'h10] !== 32'hF0F0F0F0) begin errors++; $display("FAIL amomin_mem got %h exp f0f0f0f0", mem[8'h10]); end
    run_op(LW, 4'd9, 1'b0, 1'b0, 32'h40, 32'h1);
    checks++; if (mem[8'h10] !== 32'h1) begin errors++; $display("FAIL amominu_mem got %h exp 00000001", mem[8'h10]); end
    run_op(LW, 4'd0, 1'b0, 1'b0, 32'h40, 32'h0);
    checks++; if (rdata !== 32'h1 || amo_load_val !== 32'hF0F0F0F0) begin errors++; $display("FAIL amo_hold got rdata=%h amo=%h exp 00000001/f0f0f0f0", rdata, amo_load_val); end
  endtask
  task automatic test_lrsc;
    run_op(SW, 4'd0, 1'b0, 1'b0, 32'h80, 32'h11);
    run_op(LW, 4'd0, 1'b1, 1'b0, 32'h80, 32'h0);
    checks++; if (rdata !== 32'h11 || fcnt !== 2) begin errors++; $display("FAIL lr got rdata=%h freeze=%0d exp 00000011/2", rdata, fcnt); end
    run_op(SW, 4'd0, 1'b0, 1'b1, 32'h80, 32'h22);
    checks++; if (rdata !== 32'h0 || reqs !== 1 || mem[8'h20] !== 32'h22) begin errors++; $display("FAIL sc_pass got rdata=%h req=%0d mem=%h exp 0/1/22", rdata, reqs, mem[8'h20]); end
    run_op(SW, 4'd0, 1'b0, 1'b1, 32'h80, 32'h99);
    checks++; if (rdata !== 32'h1 || reqs !== 0 || fcnt !== 1 || mem[8'h20] !== 32'h22) begin errors++; $display("FAIL sc_repeat got rdata=%h req=%0d freeze=%0d exp 1/0/1", rdata, reqs, fcnt); end
    run_op(LW, 4'd0, 1'b1, 1'b0, 32'h80, 32'h0);
    run_op(SW, 4'd0, 1'b0, 1'b0, 32'h80, 32'h33);
    run_op(SW, 4'd0, 1'b0, 1'b1, 32'h80, 32'h44);
    checks++; if (rdata !== 32'h1 || reqs !== 0 || fcnt !== 1 || mem[8'h20] !== 32'h33) begin errors++; $display("FAIL sc_after_sw got rdata=%h req=%0d freeze=%0d mem=%h exp 1/0/1/33", rdata, reqs, fcnt, mem[8'h20]); end
    run_op(LW, 4'd0, 1'b1, 1'b0, 32'h80, 32'h0);
    run_op(SW, 4'd0, 1'b0, 1'b0, 32'h84, 32'h55);
    run_op(SW, 4'd0, 1'b0, 1'b1, 32'h80, 32'h66);
    checks++; if (rdata !== 32'h0 || mem[8'h20] !== 32'h66) begin errors++; $display("FAIL sc_other_word got rdata=%h mem=%h exp 0/66", rdata, mem[8'h20]); end
  endtask
  task automatic test_misaligned;
    lsu_op = LW; addr = 32'h102;
    @(negedge clk);
    checks++; if ({addr_exception, freeze, mem_req} !== 3'b100) begin errors++; $display("FAIL lw_misalign got exc/frz/req=%b exp 100", {addr_exception, freeze, mem_req}); end
    @(posedge clk); #1 lsu_op = '0;
    @(negedge clk);
    checks++; if ({addr_exception, freeze, mem_req} !== 3'b000) begin errors++; $display("FAIL misalign_after got %b exp 000", {addr_exception, freeze, mem_req}); end
    @(posedge clk); #1 lsu_op = SH; addr = 32'h101;
    @(negedge clk);
    checks++; if ({addr_exception, freeze} !== 2'b10) begin errors++; $display("FAIL sh_misalign got %b exp 10", {addr_exception, freeze}); end
    @(posedge clk); #1 lsu_op = '0;
    run_op(LW, 4'd0, 1'b0, 1'b0, 32'h100, 32'h0);
    checks++; if (rdata !== 32'hDEADBEEF || fcnt !== 2) begin errors++; $display("FAIL after_misalign got rdata=%h freeze=%0d exp deadbeef/2", rdata, fcnt); end
  endtask
  task automatic test_wait_reset;
    wait_n = 2;
    run_op(LW, 4'd0, 1'b0, 1'b0, 32'h40, 32'h0);
    checks++; if (fcnt !== 4 || rdata !== 32'h1) begin errors++; $display("FAIL wait2 got freeze=%0d rdata=%h exp 4/00000001", fcnt, rdata); end
    wait_n = 3;
    lsu_op = LB; addr = 32'h103;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_ack !== 1'b0) begin errors++; $display("FAIL wait_req got req=%b ack=%b exp 1/0", mem_req, mem_ack); end
    @(negedge clk);
    rst = 1'b1; lsu_op = '0;
    #1;
    checks++; if ({rdata, amo_load_val, mem_wdata, mem_addr, mem_be, mem_we, mem_req, freeze, addr_exception} !== '0) begin errors++; $display("FAIL mid_reset got rdata=%h req=%b freeze=%b be=%b, all zero required", rdata, mem_req, freeze, mem_be); end
    wait_n = 0;
    #3 rst = 1'b0;
    @(posedge clk); #1;
    run_op(LW, 4'd0, 1'b0, 1'b0, 32'h100, 32'h0);
    checks++; if (rdata !== 32'hDEADBEEF || fcnt !== 2) begin errors++; $display("FAIL post_reset_op got rdata=%h freeze=%0d exp deadbeef/2", rdata, fcnt); end
  endtask
  initial begin
    test_reset;
    test_load_store;
    test_store_lanes;
    test_amo;
    test_lrsc;
    test_misaligned;
    test_wait_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
